// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: state encodings and default timing constants shared by the
// sensor emulator, the ranging driver and their benches.
package ultrasonic_pkg;
  localparam int CNT_W  = 24;
  localparam int DIST_W = 9;
  localparam int unsigned DEF_TRIG_MIN_CYCLES = 500;
  localparam int unsigned DEF_BURST_CYCLES    = 10000;
  localparam int unsigned DEF_CYCLES_PER_CM   = 2941;
  localparam int unsigned DEF_MAX_CM          = 400;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1900000;
  localparam int unsigned DEF_HOLDOFF_CYCLES  = 3000000;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;
  function automatic logic in_range(input logic [DIST_W-1:0] d, input int unsigned max_cm);
    return (d != '0) && (32'(d) <= max_cm);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/ultrasonic_sensor_emulator.sv
// ultrasonic_sensor_emulator: HC-SR04 style target emulator; validates the
// trigger width, waits a burst dead time, then emits a distance-coded echo.
module ultrasonic_sensor_emulator
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
  parameter int unsigned BURST_CYCLES    = DEF_BURST_CYCLES,
  parameter int unsigned CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
  parameter int unsigned MAX_CM          = DEF_MAX_CM,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic [2:0]        db_estado
);
  localparam logic [CNT_W-1:0] TRIG_MIN     = CNT_W'(TRIG_MIN_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPM_LAST     = CNT_W'(CYCLES_PER_CM - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);

  logic              trigger_s;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [DIST_W-1:0] cm_q, cm_d, dist_q, dist_d;
  logic              echo_q, echo_d, busy_q, busy_d, armed_q, armed_d;
  logic [1:0]        primed_q, primed_d;
  logic              oor;

  sync_2ff u_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (trigger),
    .q_o   (trigger_s)
  );

  assign oor = !in_range(dist_q, MAX_CM);

  // armed_q records a low trigger_s seen in IDLE; primed_q keeps the reset-cleared
  // synchronizer from faking that low while a held-high trigger propagates.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    cm_d     = cm_q;
    dist_d   = dist_q;
    armed_d  = armed_q;
    primed_d = {primed_q[0], 1'b1};
    case (state_q)
      ST_IDLE:
        if (armed_q && trigger_s) begin
          state_d = ST_TRIG;
          cyc_d   = '0;
          armed_d = 1'b0;
        end else if (!trigger_s && primed_q[1]) armed_d = 1'b1;
      ST_TRIG:
        if (!trigger_s) begin
          state_d = (cyc_q >= TRIG_MIN) ? ST_BURST : ST_IDLE;
          dist_d  = (cyc_q >= TRIG_MIN) ? distance_cm : dist_q;
          cyc_d   = '0;
        end else if (cyc_q < TRIG_MIN) cyc_d = cyc_q + 1'b1;
      ST_BURST:
        if (cyc_q == BURST_LAST) begin
          state_d = ST_ECHO;
          cyc_d   = '0;
          cm_d    = '0;
        end else cyc_d = cyc_q + 1'b1;
      ST_ECHO:
        if (oor) begin
          state_d = (cyc_q == TIMEOUT_LAST) ? ST_HOLDOFF : ST_ECHO;
          cyc_d   = (cyc_q == TIMEOUT_LAST) ? '0 : cyc_q + 1'b1;
        end else if (cyc_q == CPM_LAST) begin
          cyc_d   = '0;
          state_d = (cm_q == dist_q - 1'b1) ? ST_HOLDOFF : ST_ECHO;
          cm_d    = cm_q + 1'b1;
        end else cyc_d = cyc_q + 1'b1;
      ST_HOLDOFF:
        if (cyc_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
        end else cyc_d = cyc_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
    echo_d = (state_d == ST_ECHO);
    busy_d = (state_d == ST_BURST) || (state_d == ST_ECHO) || (state_d == ST_HOLDOFF);
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      cm_q     <= '0;
      dist_q   <= '0;
      echo_q   <= 1'b0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b0;
      primed_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      cm_q     <= cm_d;
      dist_q   <= dist_d;
      echo_q   <= echo_d;
      busy_q   <= busy_d;
      armed_q  <= armed_d;
      primed_q <= primed_d;
    end

  assign echo      = echo_q;
  assign busy      = busy_q;
  assign db_estado = state_q;
endmodule

// File: tb/tb_ultrasonic_sensor_emulator.sv
// tb_ultrasonic_sensor_emulator: directed and randomized measurements checked
// against timing derived from the sensor's behavioural rules.
module tb_ultrasonic_sensor_emulator;
  localparam int TMIN  = 5;
  localparam int BURST = 20;
  localparam int CPM   = 10;
  localparam int MAXCM = 400;
  localparam int TOUT  = 5000;
  localparam int HOLD  = 100;
  localparam int LAT   = 3;

  logic       clock = 1'b0;
  logic       reset, trigger, echo, busy, echo_prev = 1'b0;
  logic [8:0] distance_cm;
  logic [2:0] db_estado;
  int n_checks = 0, n_fail = 0, cyc = 0, echo_rises = 0, busy_cycles = 0, fall_cyc = 0;

  ultrasonic_sensor_emulator #(
    .TRIG_MIN_CYCLES(TMIN), .BURST_CYCLES(BURST), .CYCLES_PER_CM(CPM),
    .MAX_CM(MAXCM), .TIMEOUT_CYCLES(TOUT), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (echo && !echo_prev) echo_rises++;
    if (busy) busy_cycles++;
    echo_prev = echo;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_width(input int d);
    return (d >= 1 && d <= MAXCM) ? d * CPM : TOUT;
  endfunction

  task automatic pulse(input int w);
    @(posedge clock); #1 trigger = 1'b1;
    repeat (w) @(posedge clock);
    #1 trigger = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || db_estado != 3'd0) && k < 20000) begin @(negedge clock); k++; end
    repeat (5) @(negedge clock);
  endtask

  task automatic expect_echo(input string tag, input int width);
    int k, n, r;
    k = 0;
    while (!echo && k < BURST + 40) begin @(negedge clock); k++; end
    check({tag, ".rise"}, cyc - fall_cyc, LAT + BURST);
    n = 0;
    while (echo && n < TOUT + 100) begin @(negedge clock); n++; end
    check({tag, ".width"}, n, width);
    r = cyc;
    k = 0;
    while (busy && k < HOLD + 40) begin @(negedge clock); k++; end
    check({tag, ".hold"}, cyc - r, HOLD);
  endtask

  task automatic measure(input string tag, input int d, input int w);
    int r0, b0;
    wait_idle();
    distance_cm = 9'(d);
    r0 = echo_rises;
    b0 = busy_cycles;
    pulse(w);
    if (w > TMIN) expect_echo(tag, exp_width(d));
    else begin
      repeat (40) @(negedge clock);
      check({tag, ".no_echo"}, echo_rises - r0, 0);
      check({tag, ".no_busy"}, busy_cycles - b0, 0);
      check({tag, ".state"}, int'(db_estado), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected under 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d, w, sel;
    reset = 1'b0;
    trigger = 1'b0;
    distance_cm = '0;
    repeat (3) @(negedge clock);
    check("rst.echo", int'(echo), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.state", int'(db_estado), 0);
    reset = 1'b1;
    measure("d25", 25, 6);
    measure("short3", 25, 3);
    measure("d0", 0, 6);
    measure("d401", 401, 7);
    measure("d1", 1, 8);
    measure("d400", 400, 6);
    // distance change during BURST and stray triggers during ECHO/HOLDOFF
    wait_idle();
    distance_cm = 9'd10;
    r0 = echo_rises;
    pulse(6);
    fork
      expect_echo("latch10", 100);
      begin
        repeat (5) @(posedge clock);
        #1 distance_cm = 9'd300;
        repeat (40) @(posedge clock);
        #1 trigger = 1'b1;
        repeat (8) @(posedge clock);
        #1 trigger = 1'b0;
        repeat (80) @(posedge clock);
        #1 trigger = 1'b1;
        repeat (10) @(posedge clock);
        #1 trigger = 1'b0;
      end
    join
    repeat (60) @(negedge clock);
    check("latch10.single", echo_rises - r0, 1);
    for (int i = 0; i < 5; i++) begin
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(401, 511)) : int'($urandom_range(1, 60));
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, TMIN - 1)) : int'($urandom_range(TMIN + 1, 10));
      measure($sformatf("rnd%0d_d%0d_w%0d", i, d, w), d, w);
    end
    // reset mid-echo, then a held-high trigger must not restart a measurement
    wait_idle();
    distance_cm = 9'd25;
    pulse(6);
    for (int k = 0; k < BURST + 40 && !echo; k++) @(negedge clock);
    repeat (50) @(negedge clock);
    check("mid.echo_on", int'(echo), 1);
    #2 reset = 1'b0;
    #1;
    check("mid.echo_drop", int'(echo), 0);
    check("mid.state", int'(db_estado), 0);
    trigger = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    r0 = echo_rises;
    repeat (60) @(negedge clock);
    check("held.no_echo", echo_rises - r0, 0);
    check("held.state", int'(db_estado), 0);
    @(posedge clock); #1 trigger = 1'b0;
    repeat (4) @(posedge clock);
    distance_cm = 9'd12;
    pulse(7);
    expect_echo("rearm", 120);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ultrasonic_sensor_emulator.md
ULTRASONIC_SENSOR_EMULATOR -- requirements
Module: ultrasonic_sensor_emulator

Interface
REQ-001 SHALL have parameter TRIG_MIN_CYCLES, 500, minimum valid trigger high width (10 us @ 50 MHz).
REQ-002 SHALL have parameter BURST_CYCLES, 10000, dead time from trigger fall to echo rise (200 us).
REQ-003 SHALL have parameter CYCLES_PER_CM, 2941, echo high cycles per centimetre (58.82 us).
REQ-004 SHALL have parameter MAX_CM, 400, largest in-range distance.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 1900000, echo width for out-of-range distance (38 ms).
REQ-006 SHALL have parameter HOLDOFF_CYCLES, 3000000, dead time after echo fall (60 ms).
REQ-007 SHALL have port clock  input  1  system clock; one clock domain only.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port trigger  input  1  asynchronous trigger from the ranging driver.
REQ-010 SHALL have port distance_cm  input  9  emulated target distance, centimetres.
REQ-011 SHALL have port echo  output  1  registered echo pulse.
REQ-012 SHALL have port busy  output  1  high in BURST, ECHO, HOLDOFF.
REQ-013 SHALL have port db_estado  output  3  current state encoding.

Function
REQ-014 SHALL pass trigger through a 2-flop synchronizer; all logic uses the synchronized signal trigger_s.
REQ-015 SHALL implement states IDLE=0, TRIG=1, BURST=2, ECHO=3, HOLDOFF=4.
REQ-016 IDLE: rising edge of trigger_s -> TRIG, width counter cleared; a trigger_s high level without a preceding low SHALL NOT start a measurement.
REQ-017 TRIG: width counter increments per cycle trigger_s high, saturating at TRIG_MIN_CYCLES.
REQ-018 TRIG: on trigger_s fall with count >= TRIG_MIN_CYCLES -> BURST, distance_cm latched that cycle; with count < TRIG_MIN_CYCLES -> IDLE, no echo.
REQ-019 BURST: lasts exactly BURST_CYCLES cycles, echo low, then -> ECHO.
REQ-020 ECHO: echo high exactly d*CYCLES_PER_CM cycles where d = latched distance, 1 <= d <= MAX_CM.
REQ-021 Latched d = 0 or d > MAX_CM: echo high exactly TIMEOUT_CYCLES cycles.
REQ-022 Echo width SHALL be produced by a cycle counter (0..CYCLES_PER_CM-1) and a cm counter; no multiplier.
REQ-023 ECHO end -> HOLDOFF, echo low, lasting exactly HOLDOFF_CYCLES cycles, then -> IDLE.
REQ-024 trigger activity in BURST, ECHO, HOLDOFF SHALL be ignored; distance_cm changes after latching SHALL NOT affect the current echo.
REQ-025 On entering IDLE from HOLDOFF with trigger_s already high, a low-then-high sequence SHALL be required before TRIG.
REQ-026 echo and busy SHALL be registered outputs, glitch-free.
REQ-027 Cycle counter SHALL be 24 bits; default parameter values SHALL fit without overflow.

Reset
REQ-028 reset low SHALL immediately force state IDLE, echo=0, busy=0, db_estado=0, all counters and latched distance to 0, synchronizer flops to 0.
REQ-029 reset asserted mid-echo SHALL drop echo asynchronously; after release the block SHALL wait for a fresh trigger rising edge.

Structure
REQ-030 State encodings and default timing constants SHALL live in shared package ultrasonic_pkg, also used by the ranging driver and its bench.
REQ-031 The synchronizer SHALL be sub-module sync_2ff; the rest stays in one FSM+datapath module.

Verification (bench parameters: TRIG_MIN_CYCLES=5, BURST_CYCLES=20, CYCLES_PER_CM=10, MAX_CM=400, TIMEOUT_CYCLES=5000, HOLDOFF_CYCLES=100)
REQ-032 trigger high 6 cycles, distance_cm=25 -> echo rises 20 cycles after trigger_s fall, high exactly 250 cycles, busy low 100 cycles after echo fall.
REQ-033 trigger high 3 cycles -> no echo, busy stays 0, db_estado returns to 0.
REQ-034 distance_cm=0, then distance_cm=401, valid triggers -> echo high 5000 cycles each.
REQ-035 distance_cm=10 latched, changed to 300 during BURST, extra trigger pulses during ECHO/HOLDOFF -> echo exactly 100 cycles, single echo only.
REQ-036 reset low 50 cycles into ECHO -> echo=0 and db_estado=0 same cycle; after release, held-high trigger yields no echo until low-then-high.
